ctrl_pipeline: RTL

Carries the decoded control bundle (RegWrite, ALUSrc, MemWrite, MemRead, Branch, MemToReg, ALUop) from the ID-stage opcode decoder through the ID/EX, EX/MEM and MEM/WB pipeline registers. It is the consumer end of the decoder interface and delivers per-stage control to the EX, MEM and WB datapath. It also detects load-use hazards, inserts bubbles, handles branch flush and external memory stalls, and counts stall/bubble cycles.

---
 rtl/ctrl_pipeline.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: carries decoded control through the ID/EX, EX/MEM and MEM/WB
// registers, detects load-use hazards, squashes on taken branches, freezes on
// data-memory stalls and keeps saturating stall/bubble counters.
module ctrl_pipeline #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_RegWrite,
   input  logic                  id_ALUSrc,
   input  logic                  id_MemWrite,
   input  logic                  id_MemRead,
   input  logic                  id_Branch,
   input  logic                  id_MemToReg,
   input  logic [1:0]            id_ALUop,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_branch_taken,
   input  logic                  mem_stall,
   output logic                  ex_ALUSrc,
   output logic                  ex_Branch,
   output logic [1:0]            ex_ALUop,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_MemWrite,
   output logic                  mem_MemRead,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  wb_RegWrite,
   output logic                  wb_MemToReg,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  stall_if_id,
   output logic                  flush_if_id,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      bubble_cnt
);

   typedef struct packed {
      logic                  vld;
      logic                  RegWrite;
      logic                  ALUSrc;
      logic                  MemWrite;
      logic                  MemRead;
      logic                  Branch;
      logic                  MemToReg;
      logic [1:0]            ALUop;
      logic [REG_ADDR_W-1:0] rd;
   } idex_t;

   typedef struct packed {
      logic                  vld;
      logic                  RegWrite;
      logic                  MemWrite;
      logic                  MemRead;
      logic                  MemToReg;
      logic [REG_ADDR_W-1:0] rd;
   } exmem_t;

   typedef struct packed {
      logic                  vld;
      logic                  RegWrite;
      logic                  MemToReg;
      logic [REG_ADDR_W-1:0] rd;
   } memwb_t;

   idex_t  idex, idex_n;
   exmem_t exmem;
   memwb_t memwb;
   logic   hazard;
   logic   ins_bubble;

   // Load-use: the load in EX writes a register the ID instruction reads.
   // rd==0 never hazards since x0 is hardwired.
   assign hazard = idex.vld & idex.MemRead & (idex.rd != '0) & id_valid &
                   ((id_uses_rs1 & (id_rs1 == idex.rd)) |
                    (id_uses_rs2 & (id_rs2 == idex.rd)));

   // Priority: mem_stall freezes everything, then branch flush, then hazard.
   always_comb begin
      stall_if_id = mem_stall | (~ex_branch_taken & hazard);
      flush_if_id = ~mem_stall & ex_branch_taken;
      ins_bubble  = ~mem_stall & (ex_branch_taken | hazard);
      idex_n      = '0;
      if (id_valid && !ins_bubble) begin
         idex_n.vld      = 1'b1;
         idex_n.RegWrite = id_RegWrite;
         idex_n.ALUSrc   = id_ALUSrc;
         idex_n.MemWrite = id_MemWrite;
         idex_n.MemRead  = id_MemRead;
         idex_n.Branch   = id_Branch;
         idex_n.MemToReg = id_MemToReg;
         idex_n.ALUop    = id_ALUop;
         idex_n.rd       = id_rd;
      end
   end

   // Stage registers: all hold on mem_stall, otherwise shift one stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex  <= '0;
         exmem <= '0;
         memwb <= '0;
      end else if (!mem_stall) begin
         idex  <= idex_n;
         exmem <= '{vld: idex.vld, RegWrite: idex.RegWrite, MemWrite: idex.MemWrite,
                    MemRead: idex.MemRead, MemToReg: idex.MemToReg, rd: idex.rd};
         memwb <= '{vld: exmem.vld, RegWrite: exmem.RegWrite,
                    MemToReg: exmem.MemToReg, rd: exmem.rd};
      end
   end

   // Saturating performance counters; they stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall_if_id && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (ins_bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

   // Per-stage control is gated by valid so a bubble can never assert anything.
   assign ex_ALUSrc    = idex.vld & idex.ALUSrc;
   assign ex_Branch    = idex.vld & idex.Branch;
   assign ex_ALUop     = idex.vld ? idex.ALUop : 2'b00;
   assign ex_rd        = idex.vld ? idex.rd : '0;
   assign mem_MemWrite = exmem.vld & exmem.MemWrite;
   assign mem_MemRead  = exmem.vld & exmem.MemRead;
   assign mem_rd       = exmem.vld ? exmem.rd : '0;
   assign wb_RegWrite  = memwb.vld & memwb.RegWrite;
   assign wb_MemToReg  = memwb.vld & memwb.MemToReg;
   assign wb_rd        = memwb.vld ? memwb.rd : '0;

endmodule
